// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter.
//   uart_state_t    : receiver FSM state encodings
//   uart_ticks_t    : bit-period and half-bit-period lengths in clock cycles
//   uart_calc_ticks : derives uart_ticks_t from the clock frequency and baud rate
//                     (integer truncation, identical arithmetic on rx and tx)
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } uart_state_t;

   typedef struct packed {
      int unsigned bit_ticks;
      int unsigned half_ticks;
   } uart_ticks_t;

   function automatic uart_ticks_t uart_calc_ticks(input int unsigned clk_freq,
                                                   input int unsigned baud);
      uart_ticks_t t;
      t.bit_ticks  = clk_freq / baud;
      t.half_ticks = t.bit_ticks / 2;
      return t;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchroniser for a single asynchronous input.
// Parameters:
//   RESET_VAL : value both flops take during reset (1 suits an idle-high line)
// Ports:
//   clk : destination clock
//   rst : asynchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronised output, two clk cycles behind d
// -----------------------------------------------------------------------------
module uart_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1 by default (start, 8 data bits LSB first, stop).
// The line is synchronised, the start bit is validated at mid-bit and every
// following bit is sampled at mid-bit. Received bytes land in a one-entry
// holding register read through a ready/read handshake.
//
// Optional feature: define UART_RX_PARITY_EN to insert a parity bit after the
// data bits; parameter PARITY_ODD (0 = even, 1 = odd) selects its sense and only
// exists in that build. Without the macro parity_err is tied low.
//
// Parameters:
//   CLK_FREQ : system clock frequency in Hz
//   BAUD     : line rate in bit/s
// Ports:
//   clk        : system clock, all logic on posedge
//   rst        : asynchronous, active-high reset
//   rx         : serial line, asynchronous, idle high
//   read_en    : consumer pops the holding register this cycle
//   data       : holding register contents
//   data_ready : holding register holds an unread byte
//   overrun    : sticky, a byte was committed over an unread one
//   frame_err  : one-cycle pulse, stop bit sampled low (byte discarded)
//   parity_err : one-cycle pulse in the commit cycle on parity mismatch
//   rx_busy    : receiver FSM not idle
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 1_000_000,
   parameter int unsigned BAUD     = 9600
`ifdef UART_RX_PARITY_EN
   ,
   parameter logic        PARITY_ODD = 1'b0
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       read_en,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       overrun,
   output logic       frame_err,
   output logic       parity_err,
   output logic       rx_busy
);

   localparam uart_ticks_t TICKS      = uart_calc_ticks(CLK_FREQ, BAUD);
   localparam int unsigned BIT_TICKS  = TICKS.bit_ticks;
   localparam int unsigned HALF_TICKS = TICKS.half_ticks;
   localparam int          CNT_W      = $clog2(BIT_TICKS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);

   logic              w_rx_s;
   uart_state_t       r_state;
   uart_state_t       w_state_next;
   logic [CNT_W-1:0]  r_baud_cnt;
   logic [2:0]        r_bit_cnt;
   logic [7:0]        r_shift;
   logic [7:0]        r_data;
   logic              r_data_ready;
   logic              r_overrun;
   logic              r_commit;
   logic              r_frame_err;

   // FSM strobes
   logic              w_cnt_clr;
   logic              w_shift_en;
   logic              w_commit_set;
   logic              w_ferr_set;

   uart_sync #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (w_rx_s)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic w_par_en;
`endif

   always_comb begin
      w_state_next = r_state;
      w_cnt_clr    = 1'b0;
      w_shift_en   = 1'b0;
      w_commit_set = 1'b0;
      w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_en     = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            w_cnt_clr = 1'b1;
            if (!w_rx_s) begin
               w_state_next = ST_START;
            end
         end
         ST_START: begin
            // Mid-start-bit check: a line back high here was only a glitch.
            if (r_baud_cnt == HALF_LAST) begin
               w_cnt_clr    = 1'b1;
               w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_baud_cnt == BIT_LAST) begin
               w_cnt_clr  = 1'b1;
               w_shift_en = 1'b1;
               if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_next = ST_PARITY;
`else
                  w_state_next = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (r_baud_cnt == BIT_LAST) begin
               w_cnt_clr    = 1'b1;
               w_par_en     = 1'b1;
               w_state_next = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (r_baud_cnt == BIT_LAST) begin
               w_cnt_clr = 1'b1;
               if (w_rx_s) begin
                  w_commit_set = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_ferr_set   = 1'b1;
                  w_state_next = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            // A held-low line (break) must not be mistaken for a new start bit.
            w_cnt_clr = 1'b1;
            if (w_rx_s) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_cnt_clr    = 1'b1;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud_cnt  <= '0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_commit    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_baud_cnt  <= w_cnt_clr ? '0 : r_baud_cnt + CNT_W'(1);
         // bit_cnt only advances inside DATA, so it is zero on every entry.
         if (r_state != ST_DATA) begin
            r_bit_cnt <= 3'd0;
         end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_shift_en) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
         end
         r_commit    <= w_commit_set;
         r_frame_err <= w_ferr_set;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_bad;
   logic r_parity_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if (w_par_en) begin
            r_par_bad <= (w_rx_s != ((^r_shift) ^ PARITY_ODD));
         end
         // Reported alongside the commit; the byte is delivered regardless.
         r_parity_err <= w_commit_set & r_par_bad;
      end
   end

   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   // ---------------------------------------------------------------- holding register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data       <= 8'h00;
         r_data_ready <= 1'b0;
         r_overrun    <= 1'b0;
      end else if (r_commit) begin
         r_data       <= r_shift;
         r_data_ready <= 1'b1;
         // A read in the commit cycle consumes the old byte, so no overrun.
         if (r_data_ready && !read_en) begin
            r_overrun <= 1'b1;
         end else if (r_data_ready && read_en) begin
            r_overrun <= 1'b0;
         end
      end else if (read_en && r_data_ready) begin
         r_data_ready <= 1'b0;
         r_overrun    <= 1'b0;
      end
   end

   assign data       = r_data;
   assign data_ready = r_data_ready;
   assign overrun    = r_overrun;
   assign frame_err  = r_frame_err;
   assign rx_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed testbench for uart_rx at CLK_FREQ=1 MHz, BAUD=9600 (104 cycles/bit).
// Frames are serialised by a bench task; inputs change and outputs are
// sampled on the falling clock edge. Define UART_RX_PARITY_EN to exercise the
// parity build.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 1_000_000;
   localparam int unsigned BAUD     = 9600;
   localparam int          BIT      = 104;
   localparam int          HALF     = 52;
`ifdef UART_RX_PARITY_EN
   localparam int          PAR_BITS = 1;
`else
   localparam int          PAR_BITS = 0;
`endif
   // Falling edge (counted from the start-bit edge) inside the commit cycle:
   // 3 cycles to reach START, half a bit, then data/parity/stop bits.
   localparam int          COMMIT_NEG = 3 + HALF + BIT * (9 + PAR_BITS);

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       read_en;
   logic [7:0] data;
   logic       data_ready;
   logic       overrun;
   logic       frame_err;
   logic       parity_err;
   logic       rx_busy;

   int n_cmp    = 0;
   int n_bad    = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;

   logic [7:0] lb_bytes [3] = '{8'h00, 8'hFF, 8'h81};

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .read_en    (read_en),
      .data       (data),
      .data_ready (data_ready),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .rx_busy    (rx_busy)
   );

   // Pulse counters for the one-cycle error strobes.
   always @(negedge clk) begin
      if (frame_err === 1'b1) ferr_cnt++;
      if (parity_err === 1'b1) perr_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_read();
      read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
   endtask

   // Leaves rx at the stop-bit level so a low stop can be extended by the caller.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
      $display("tx frame byte=0x%02h stop=%0b parity_flip=%0b", b, stop_v, par_flip);
      rx = 1'b0;
      idle(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(BIT);
      end
      if (PAR_BITS != 0) begin
         rx = (^b) ^ par_flip;
         idle(BIT);
      end
      rx = stop_v;
      idle(BIT);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      rx      = 1'b1;
      read_en = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      check_eq("rst_data",       32'(data),       32'h00);
      check_eq("rst_data_ready", 32'(data_ready), 32'h0);
      check_eq("rst_overrun",    32'(overrun),    32'h0);
      check_eq("rst_frame_err",  32'(frame_err),  32'h0);
      check_eq("rst_parity_err", 32'(parity_err), 32'h0);
      check_eq("rst_rx_busy",    32'(rx_busy),    32'h0);
      rst = 1'b0;
      idle(10);

      // Plain byte
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(5);
      check_eq("a5_data",     32'(data),       32'hA5);
      check_eq("a5_ready",    32'(data_ready), 32'h1);
      check_eq("a5_overrun",  32'(overrun),    32'h0);
      check_eq("a5_busy",     32'(rx_busy),    32'h0);
      check_eq("a5_ferr_cnt", 32'(ferr_cnt),   32'd0);
      pulse_read();
      check_eq("a5_read_ready", 32'(data_ready), 32'h0);

      // Start-bit glitch
      $display("tx glitch 20 cycles low");
      rx = 1'b0;
      idle(20);
      check_eq("glitch_busy_mid", 32'(rx_busy), 32'h1);
      rx = 1'b1;
      idle(100);
      check_eq("glitch_busy_end", 32'(rx_busy),    32'h0);
      check_eq("glitch_ready",    32'(data_ready), 32'h0);
      check_eq("glitch_ferr_cnt", 32'(ferr_cnt),   32'd0);

      // Framing error followed by a held-low line
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(300);
      check_eq("ferr_cnt",       32'(ferr_cnt),   32'd1);
      check_eq("ferr_ready",     32'(data_ready), 32'h0);
      check_eq("ferr_busy_low",  32'(rx_busy),    32'h1);
      rx = 1'b1;
      idle(10);
      check_eq("ferr_busy_idle", 32'(rx_busy),    32'h0);
      send_frame(8'h55, 1'b1, 1'b0);
      idle(5);
      check_eq("after_ferr_data",  32'(data),       32'h55);
      check_eq("after_ferr_ready", 32'(data_ready), 32'h1);
      check_eq("after_ferr_cnt",   32'(ferr_cnt),   32'd1);
      pulse_read();

      // Overrun
      send_frame(8'h11, 1'b1, 1'b0);
      idle(20);
      send_frame(8'h22, 1'b1, 1'b0);
      idle(5);
      check_eq("ovr_data",    32'(data),       32'h22);
      check_eq("ovr_ready",   32'(data_ready), 32'h1);
      check_eq("ovr_overrun", 32'(overrun),    32'h1);
      pulse_read();
      check_eq("ovr_read_ready",   32'(data_ready), 32'h0);
      check_eq("ovr_read_overrun", 32'(overrun),    32'h0);

      // Read exactly in the commit cycle of the next byte
      send_frame(8'h66, 1'b1, 1'b0);
      idle(20);
      check_eq("cr_first_data", 32'(data), 32'h66);
      fork
         send_frame(8'h77, 1'b1, 1'b0);
         begin
            idle(COMMIT_NEG);
            read_en = 1'b1;
            @(negedge clk);
            read_en = 1'b0;
         end
      join
      check_eq("cr_data",    32'(data),       32'h77);
      check_eq("cr_ready",   32'(data_ready), 32'h1);
      check_eq("cr_overrun", 32'(overrun),    32'h0);
      pulse_read();

      // Loopback bytes; the last one is left unread
      for (int i = 0; i < 3; i++) begin
         send_frame(lb_bytes[i], 1'b1, 1'b0);
         idle(5);
         check_eq("lb_data",    32'(data),       32'(lb_bytes[i]));
         check_eq("lb_ready",   32'(data_ready), 32'h1);
         if (i < 2) pulse_read();
      end
      send_frame(8'h42, 1'b1, 1'b0);
      idle(5);
      check_eq("lb_ovr_data",    32'(data),    32'h42);
      check_eq("lb_ovr_overrun", 32'(overrun), 32'h1);

      // Reset in the middle of a frame
      $display("tx partial frame, reset mid-frame");
      rx = 1'b0;
      idle(300);
      check_eq("midrst_busy_before", 32'(rx_busy), 32'h1);
      rst = 1'b1;
      rx  = 1'b1;
      idle(2);
      check_eq("midrst_data",    32'(data),       32'h00);
      check_eq("midrst_ready",   32'(data_ready), 32'h0);
      check_eq("midrst_overrun", 32'(overrun),    32'h0);
      check_eq("midrst_busy",    32'(rx_busy),    32'h0);
      check_eq("midrst_ferr",    32'(frame_err),  32'h0);
      rst = 1'b0;
      idle(20);
      send_frame(8'h5A, 1'b1, 1'b0);
      idle(5);
      check_eq("postrst_data",    32'(data),       32'h5A);
      check_eq("postrst_ready",   32'(data_ready), 32'h1);
      check_eq("postrst_overrun", 32'(overrun),    32'h0);
      pulse_read();

`ifdef UART_RX_PARITY_EN
      check_eq("par_clean_cnt", 32'(perr_cnt), 32'd0);
      send_frame(8'hC3, 1'b1, 1'b1);
      idle(5);
      check_eq("par_err_cnt", 32'(perr_cnt),   32'd1);
      check_eq("par_data",    32'(data),       32'hC3);
      check_eq("par_ready",   32'(data_ready), 32'h1);
      pulse_read();
`else
      check_eq("par_tied_cnt", 32'(perr_cnt), 32'd0);
`endif
      check_eq("final_ferr_cnt", 32'(ferr_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
